// File: rtl/rca_writeback_buffer.sv
// -----------------------------------------------------------------------------
// rca_writeback_buffer
//
// In-order completion queue between the RCA execution pipeline and the
// register-file writeback stage. Each entry holds one instruction ID plus
// NUM_WRITE_PORTS (destination register, data) pairs. The head entry is shown
// on the wb_* outputs (first-word fall-through) and is retired by wb_ack.
// Ports whose write enable is low store rd_addr 0, so the downstream commit
// for that port is suppressed.
//
// Optional build macro:
//   RCA_WB_BYPASS_EN - when the buffer is empty, an offered completion is shown
//                      on wb_* in the same cycle. If it is acked in that cycle
//                      it is consumed without ever being written.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   res_valid/ready  completion handshake from the RCA pipeline
//   res_id           instruction ID of the offered completion
//   res_we           per-port write enable
//   res_rd_addr      per-port destination register
//   res_data         per-port result data
//   flush            discard every buffered entry (wins over push and ack)
//   wb_done/wb_ack   head-valid / head-consumed handshake to writeback
//   wb_id            head instruction ID
//   wb_rd            head per-port data
//   wb_rd_addr       head per-port destination (0 on disabled ports)
//   wb_id_for_rd     head ID replicated per port, for the RF banks and LVTs
//   occupancy        number of entries held
// -----------------------------------------------------------------------------
module rca_writeback_buffer #(
  parameter int DEPTH           = 4,
  parameter int NUM_WRITE_PORTS = 3,
  parameter int ID_W            = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  res_valid,
  output logic                                  res_ready,
  input  logic [ID_W-1:0]                       res_id,
  input  logic [NUM_WRITE_PORTS-1:0]            res_we,
  input  logic [NUM_WRITE_PORTS-1:0][4:0]       res_rd_addr,
  input  logic [NUM_WRITE_PORTS-1:0][31:0]      res_data,
  input  logic                                  flush,
  output logic                                  wb_done,
  input  logic                                  wb_ack,
  output logic [ID_W-1:0]                       wb_id,
  output logic [NUM_WRITE_PORTS-1:0][31:0]      wb_rd,
  output logic [NUM_WRITE_PORTS-1:0][4:0]       wb_rd_addr,
  output logic [NUM_WRITE_PORTS-1:0][ID_W-1:0]  wb_id_for_rd,
  output logic [$clog2(DEPTH):0]                occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef struct packed {
    logic [ID_W-1:0]                  id;
    logic [NUM_WRITE_PORTS-1:0][4:0]  rd_addr;
    logic [NUM_WRITE_PORTS-1:0][31:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          out_entry;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            head_valid;
  logic            push;
  logic            pop;

  // Disabled ports carry rd_addr 0 so the register file ignores them.
  always_comb begin
    in_entry      = '0;
    in_entry.id   = res_id;
    in_entry.data = res_data;
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      in_entry.rd_addr[p] = res_we[p] ? res_rd_addr[p] : 5'd0;
    end
  end

  assign head_valid = (count != '0);
  // Depends on count only: a full buffer stalls even while the head is acked.
  assign res_ready  = (count != COUNT_FULL);
  assign pop        = head_valid && wb_ack;
  assign occupancy  = count;

`ifdef RCA_WB_BYPASS_EN
  logic bypass;
  assign bypass    = !head_valid && res_valid;
  assign out_entry = bypass ? in_entry : mem[rptr];
  assign wb_done   = head_valid || res_valid;
  // A bypassed completion that is acked at once never enters storage.
  assign push      = res_valid && res_ready && !(bypass && wb_ack);
`else
  assign out_entry = mem[rptr];
  assign wb_done   = head_valid;
  assign push      = res_valid && res_ready;
`endif

  always_comb begin
    wb_id      = out_entry.id;
    wb_rd      = out_entry.data;
    wb_rd_addr = out_entry.rd_addr;
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      wb_id_for_rd[p] = out_entry.id;
    end
  end

  // Control state: flush shares the reset path and overrides push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry array is deliberately not reset; count gates every read,
  // so stale contents are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wptr] <= in_entry;
    end
  end

  // Simulation checks on the occupancy bookkeeping.
  a_no_accept_when_full : assert property (@(posedge clk) disable iff (rst)
    !(res_valid && res_ready && count == COUNT_FULL));
  a_count_bounded : assert property (@(posedge clk) disable iff (rst)
    count <= COUNT_FULL);

endmodule

// File: tb/tb_rca_writeback_buffer.sv
// -----------------------------------------------------------------------------
// tb_rca_writeback_buffer
//
// Directed bench for rca_writeback_buffer (DEPTH=4, 3 ports, ID_W=3). Each
// scenario task drives its own stimulus and compares outputs against
// hand-computed values. Inputs change 1 time unit after the rising edge and
// outputs are sampled 1 unit later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_rca_writeback_buffer;

  localparam int DEPTH = 4;
  localparam int NWP   = 3;
  localparam int ID_W  = 3;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          res_valid;
  logic                          res_ready;
  logic [ID_W-1:0]               res_id;
  logic [NWP-1:0]                res_we;
  logic [NWP-1:0][4:0]           res_rd_addr;
  logic [NWP-1:0][31:0]          res_data;
  logic                          flush;
  logic                          wb_done;
  logic                          wb_ack;
  logic [ID_W-1:0]               wb_id;
  logic [NWP-1:0][31:0]          wb_rd;
  logic [NWP-1:0][4:0]           wb_rd_addr;
  logic [NWP-1:0][ID_W-1:0]      wb_id_for_rd;
  logic [$clog2(DEPTH):0]        occupancy;

  int tests_run = 0;
  int tests_failed = 0;

  rca_writeback_buffer #(
    .DEPTH(DEPTH), .NUM_WRITE_PORTS(NWP), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_we(res_we), .res_rd_addr(res_rd_addr), .res_data(res_data),
    .flush(flush),
    .wb_done(wb_done), .wb_ack(wb_ack), .wb_id(wb_id), .wb_rd(wb_rd),
    .wb_rd_addr(wb_rd_addr), .wb_id_for_rd(wb_id_for_rd),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    res_valid   = 1'b0;
    res_id      = '0;
    res_we      = '0;
    res_rd_addr = '0;
    res_data    = '0;
    flush       = 1'b0;
    wb_ack      = 1'b0;
  endtask

  // Offer a completion with all ports enabled (stimulus only, no checks).
  task automatic offer(input logic [ID_W-1:0] id);
    res_valid = 1'b1;
    res_id    = id;
    res_we    = 3'b111;
    for (int p = 0; p < NWP; p++) begin
      res_rd_addr[p] = 5'(id) + 5'(p) + 5'd1;
      res_data[p]    = 32'h100 * 32'(id) + 32'(p);
    end
  endtask

  task automatic push_one(input logic [ID_W-1:0] id);
    offer(id);
    tick();
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests_run++; if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_done got=%b exp=0", wb_done); end
    tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    tests_run++; if (res_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_res_ready got=%b exp=1", res_ready); end
  endtask

  task automatic test_single_push();
    logic [NWP-1:0][4:0]      exp_addr;
    logic [NWP-1:0][ID_W-1:0] exp_ids;
    exp_addr[0] = 5'd5; exp_addr[1] = 5'd0; exp_addr[2] = 5'd9;
    exp_ids     = {3'd2, 3'd2, 3'd2};
    res_valid      = 1'b1;
    res_id         = 3'd2;
    res_we         = 3'b101;
    res_rd_addr[0] = 5'd5; res_rd_addr[1] = 5'd7; res_rd_addr[2] = 5'd9;
    res_data[0]    = 32'hA; res_data[1] = 32'hB; res_data[2] = 32'hC;
    #1;
`ifdef RCA_WB_BYPASS_EN
    tests_run++; if (wb_done !== 1'b1) begin tests_failed++; $display("FAIL single_bypass_done got=%b exp=1", wb_done); end
`else
    tests_run++; if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL single_same_cycle_done got=%b exp=0", wb_done); end
`endif
    tick();
    idle_inputs();
    #1;
    tests_run++; if (wb_done !== 1'b1) begin tests_failed++; $display("FAIL single_done got=%b exp=1", wb_done); end
    tests_run++; if (wb_id !== 3'd2) begin tests_failed++; $display("FAIL single_id got=%0d exp=2", wb_id); end
    tests_run++; if (wb_rd_addr !== exp_addr) begin tests_failed++; $display("FAIL single_rd_addr got=%h exp=%h", wb_rd_addr, exp_addr); end
    tests_run++; if (wb_rd[0] !== 32'hA || wb_rd[2] !== 32'hC) begin tests_failed++; $display("FAIL single_data got=%h/%h exp=a/c", wb_rd[0], wb_rd[2]); end
    tests_run++; if (wb_id_for_rd !== exp_ids) begin tests_failed++; $display("FAIL single_id_for_rd got=%h exp=%h", wb_id_for_rd, exp_ids); end
    tests_run++; if (occupancy !== 3'd1) begin tests_failed++; $display("FAIL single_occ got=%0d exp=1", occupancy); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    #1;
    tests_run++; if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL single_ack_done got=%b exp=0", wb_done); end
    tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL single_ack_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      offer(3'(i));
      tick();
    end
    offer(3'd5);
    #1;
    tests_run++; if (res_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_ready got=%b exp=0", res_ready); end
    tests_run++; if (occupancy !== 3'd4) begin tests_failed++; $display("FAIL fill_occ got=%0d exp=4", occupancy); end
    tick();
    res_valid = 1'b0;
    #1;
    tests_run++; if (occupancy !== 3'd4) begin tests_failed++; $display("FAIL fill_held_off got=%0d exp=4", occupancy); end
    for (int i = 1; i <= 4; i++) begin
      wb_ack = 1'b1;
      #1;
      tests_run++; if (wb_id !== 3'(i)) begin tests_failed++; $display("FAIL fill_order_%0d got=%0d exp=%0d", i, wb_id, i); end
      tick();
    end
    wb_ack = 1'b0;
    #1;
    tests_run++; if (wb_done !== 1'b0 || occupancy !== 3'd0) begin tests_failed++; $display("FAIL fill_drained done=%b occ=%0d exp 0/0", wb_done, occupancy); end
  endtask

  task automatic test_wrap();
    logic [23:0]     pat = 24'b1011_0111_1101_0110_1110_1011;
    logic [ID_W-1:0] q[$];
    int              pushed = 0;
    int              got = 0;
    int              max_occ = 0;
    int              cyc = 0;
    while (got < 10 && cyc < 60) begin
      res_valid = pat[cyc % 24] && (pushed < 10);
      res_id    = 3'((pushed * 3 + 1) % 8);
      wb_ack    = (occupancy != 0);
      #1;
      if (wb_ack && wb_done) begin
        if (q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL wrap_unexpected_pop got=%0d exp=none", wb_id);
        end else begin
          tests_run++; if (wb_id !== q[0]) begin tests_failed++; $display("FAIL wrap_order_%0d got=%0d exp=%0d", got, wb_id, q[0]); end
          void'(q.pop_front());
          got++;
        end
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (res_valid && res_ready) begin
        q.push_back(res_id);
        pushed++;
      end
      tick();
      cyc++;
    end
    idle_inputs();
    #1;
    tests_run++; if (got != 10) begin tests_failed++; $display("FAIL wrap_count got=%0d exp=10", got); end
    tests_run++; if (max_occ > DEPTH) begin tests_failed++; $display("FAIL wrap_max_occ got=%0d exp<=4", max_occ); end
    tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL wrap_final_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_back_to_back();
    push_one(3'd3);
    push_one(3'd4);
    offer(3'd5);
    wb_ack = 1'b1;
    #1;
    tests_run++; if (wb_id !== 3'd3 || occupancy !== 3'd2) begin tests_failed++; $display("FAIL b2b_pre id=%0d occ=%0d exp 3/2", wb_id, occupancy); end
    tick();
    idle_inputs();
    #1;
    tests_run++; if (occupancy !== 3'd2) begin tests_failed++; $display("FAIL b2b_occ2 got=%0d exp=2", occupancy); end
    tests_run++; if (wb_id !== 3'd4) begin tests_failed++; $display("FAIL b2b_head got=%0d exp=4", wb_id); end
    wb_ack = 1'b1;
    tick();
    offer(3'd6);
    #1;
    tests_run++; if (wb_id !== 3'd5 || occupancy !== 3'd1) begin tests_failed++; $display("FAIL b2b_one id=%0d occ=%0d exp 5/1", wb_id, occupancy); end
    tick();
    idle_inputs();
    #1;
    tests_run++; if (occupancy !== 3'd1 || wb_id !== 3'd6) begin tests_failed++; $display("FAIL b2b_occ1 occ=%0d id=%0d exp 1/6", occupancy, wb_id); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    #1;
    tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL b2b_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_flush();
    push_one(3'd1);
    push_one(3'd2);
    push_one(3'd3);
    offer(3'd7);
    flush  = 1'b1;
    wb_ack = 1'b1;
    tick();
    idle_inputs();
    #1;
    tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    tests_run++; if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL flush_done got=%b exp=0", wb_done); end
    tests_run++; if (res_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready got=%b exp=1", res_ready); end
    push_one(3'd6);
    #1;
    tests_run++; if (wb_id !== 3'd6 || occupancy !== 3'd1) begin tests_failed++; $display("FAIL flush_after id=%0d occ=%0d exp 6/1", wb_id, occupancy); end
    tests_run++; if (wb_rd[1] !== 32'h601) begin tests_failed++; $display("FAIL flush_after_data got=%h exp=601", wb_rd[1]); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
  endtask

  task automatic test_bypass();
    logic [NWP-1:0][4:0] exp_addr;
    exp_addr[0] = 5'd0; exp_addr[1] = 5'd2; exp_addr[2] = 5'd0;
    res_valid      = 1'b1;
    res_id         = 3'd5;
    res_we         = 3'b010;
    res_rd_addr[0] = 5'd1; res_rd_addr[1] = 5'd2; res_rd_addr[2] = 5'd3;
    res_data       = '0;
    wb_ack         = 1'b1;
    #1;
`ifdef RCA_WB_BYPASS_EN
    tests_run++; if (wb_done !== 1'b1) begin tests_failed++; $display("FAIL bypass_done got=%b exp=1", wb_done); end
    tests_run++; if (wb_id !== 3'd5 || wb_rd_addr !== exp_addr) begin tests_failed++; $display("FAIL bypass_head id=%0d addr=%h exp 5/%h", wb_id, wb_rd_addr, exp_addr); end
    tick();
    idle_inputs();
    #1;
    tests_run++; if (occupancy !== 3'd0 || wb_done !== 1'b0) begin tests_failed++; $display("FAIL bypass_consumed occ=%0d done=%b exp 0/0", occupancy, wb_done); end
`else
    tests_run++; if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL nobypass_done got=%b exp=0", wb_done); end
    tick();
    idle_inputs();
    #1;
    tests_run++; if (occupancy !== 3'd1) begin tests_failed++; $display("FAIL nobypass_occ got=%0d exp=1", occupancy); end
    tests_run++; if (wb_id !== 3'd5 || wb_rd_addr !== exp_addr) begin tests_failed++; $display("FAIL nobypass_head id=%0d addr=%h exp 5/%h", wb_id, wb_rd_addr, exp_addr); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    #1;
    tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL nobypass_drain got=%0d exp=0", occupancy); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rca_writeback_buffer.md
Name: rca_writeback_buffer

Overview:
- Decoupling queue between the RCA execution pipeline and the register-file/writeback stage.
- Captures multi-result RCA completions: one ID plus NUM_WRITE_PORTS destination registers and data.
- Presents completions in order on the RCA writeback done/ack handshake.
- Drives the per-port RCA retired rd addresses and IDs consumed by the RCA register-file banks and LVTs.

Parameters:
- DEPTH, 4, number of completion entries; power of two, minimum 2.
- NUM_WRITE_PORTS, 3, register results per RCA completion.
- ID_W, 3, width of instruction ID.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- res_valid  in  1  RCA completion offered this cycle.
- res_ready  out  1  buffer can accept; a transfer occurs when res_valid & res_ready.
- res_id  in  ID_W  instruction ID of completion.
- res_we  in  NUM_WRITE_PORTS  per-port write enable.
- res_rd_addr  in  NUM_WRITE_PORTS x 5  per-port destination register.
- res_data  in  NUM_WRITE_PORTS x 32  per-port result.
- flush  in  1  discard all buffered entries (pipeline flush).
- wb_done  out  1  head entry valid.
- wb_ack  in  1  writeback consumed head; only honoured when wb_done=1.
- wb_id  out  ID_W  head ID.
- wb_rd  out  NUM_WRITE_PORTS x 32  head data.
- wb_rd_addr  out  NUM_WRITE_PORTS x 5  head rd addr; a port with we=0 drives 5'd0.
- wb_id_for_rd  out  NUM_WRITE_PORTS x ID_W  head ID replicated per port.
- occupancy  out  $clog2(DEPTH)+1  entries held.

Behaviour:
- Storage: circular buffer of DEPTH entries; read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH; separate count register.
- Reset and flush: count=0 and both pointers=0. Outputs are wb_done=0, occupancy=0 and res_ready=1 from the next cycle. flush has priority over a same-cycle push and ack.
- Acceptance: res_ready = (count != DEPTH). It has no combinational dependence on wb_ack, so a full buffer stalls the RCA for one cycle even if the head is being acked.
- Push: on accept, write the entry at wptr and increment wptr. Ports with res_we=0 store rd_addr=0 so that the downstream commit is suppressed.
- Pop: when wb_done & wb_ack, increment rptr. wb_ack while wb_done=0 is ignored.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: an entry accepted in cycle N is visible on wb_* in cycle N+1 at the earliest, head-of-queue permitting.
- Outputs: wb_* are driven from the head entry (first-word fall-through from storage). wb_done = (count != 0).
- Ordering: strict FIFO. No reordering by ID.
- Stability: head outputs stay stable while wb_done=1 and wb_ack=0.
- Empty/full boundaries: a simultaneous push and pop with count=1 leaves count=1 with the new head. A push into an empty buffer is never popped in the same cycle.
- Assertions (simulation only): no accept when count==DEPTH; count never exceeds DEPTH.

Optional Feature:
- RCA_WB_BYPASS_EN defined:
  - When count==0 and res_valid=1, wb_* is driven combinationally from res_* in the same cycle.
  - If wb_ack=1 that cycle, the entry is consumed without being written and count stays 0.
  - res_ready is unchanged.
- RCA_WB_BYPASS_EN undefined: minimum latency is 1 cycle, as specified in Behaviour.

Test Plan:
- Reset then single push: res_id=2, we=3'b101, addrs {5,7,9}, data {A,B,C} -> next cycle wb_done=1, wb_id=2, wb_rd_addr={5,0,9}; ack -> wb_done=0, occupancy=0.
- Fill: 4 pushes with no ack -> res_ready=0 after the 4th, occupancy=4; a 5th res_valid is held off; ack x4 returns IDs in push order.
- Wrap-around: 10 push/ack pairs at one per cycle with a random gap pattern -> IDs out match IDs in, pointers wrap, occupancy never exceeds 4.
- Simultaneous push+ack at occupancy=2 -> occupancy stays 2, head advances to the next ID.
- Flush with 3 entries plus a same-cycle push -> next cycle occupancy=0, wb_done=0; later pushes are unaffected.
- With RCA_WB_BYPASS_EN: empty buffer, res_valid with wb_ack=1 same cycle -> wb_done=1 that cycle, occupancy remains 0. Without the macro -> wb_done=0 that cycle.
